// File: rtl/serial_word_tx.sv
// serial_word_tx: word-to-serial MSB-first transmitter with idle gap; optional parity via SERIAL_WORD_TX_PARITY_EN
module serial_word_tx #(
    parameter int WIDTH = 3,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_start,
    output logic             word_done,
    output logic             busy
);
`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);
    localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] CLAST = CW'(FRAME - 1);
    localparam logic [GW-1:0] GLAST = GW'(GAP > 0 ? GAP - 1 : 0);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic hold_full, hold_full_n;
    logic [FRAME-1:0] shifter, shifter_n, load_val;
    logic [CW-1:0] cnt, cnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic load, transfer;
`ifdef SERIAL_WORD_TX_PARITY_EN
    assign load_val = {hold, ^hold};
`else
    assign load_val = hold;
`endif
    assign transfer = data_valid && !hold_full;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shifter   <= '0;
            cnt       <= '0;
            gcnt      <= '0;
        end else begin
            state     <= state_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            shifter   <= shifter_n;
            cnt       <= cnt_n;
            gcnt      <= gcnt_n;
        end
    end
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        gcnt_n    = gcnt;
        shifter_n = shifter;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    cnt_n   = '0;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shifter_n = {shifter[FRAME-2:0], 1'b0};
                cnt_n     = cnt + 1'b1;
                if (cnt == CLAST) begin
                    if (GAP > 0) begin
                        state_n = S_GAP;
                        gcnt_n  = '0;
                    end else if (hold_full) begin
                        load  = 1'b1;
                        cnt_n = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gcnt == GLAST) begin
                    if (hold_full) begin
                        load    = 1'b1;
                        cnt_n   = '0;
                        state_n = S_SHIFT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (load) shifter_n = load_val;
        hold_full_n = transfer || (hold_full && !load);
        hold_n      = transfer ? data_in : hold;
    end
    assign data_ready = !hold_full;
    assign sout       = state == S_SHIFT && shifter[FRAME-1];
    assign sout_valid = state == S_SHIFT;
    assign word_start = state == S_SHIFT && cnt == '0;
    assign word_done  = state == S_SHIFT && cnt == CLAST;
    assign busy       = state != S_IDLE || hold_full;
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed table and sequence checks for serial_word_tx (GAP=2 and GAP=0 instances)
module tb_serial_word_tx;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] din2 = '0, din0 = '0;
    logic dv2 = 1'b0, dv0 = 1'b0;
    logic rdy2, so2, sv2, ws2, wd2, bz2;
    logic rdy0, so0, sv0, ws0, wd0, bz0;
    int errors = 0, checks = 0, cyc = 0;
    logic [7:0] acc2 = '0, acc0 = '0;
    int nb2 = 0, nb0 = 0, nvalid0 = 0, first0 = -1, last0 = -1;
    logic [7:0] rx2[$], rx0[$];
    int rxn2[$], st2[$];

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(3), .GAP(2)) u2 (
        .clk(clk), .rst(rst), .data_in(din2), .data_valid(dv2), .data_ready(rdy2),
        .sout(so2), .sout_valid(sv2), .word_start(ws2), .word_done(wd2), .busy(bz2)
    );
    serial_word_tx #(.WIDTH(3), .GAP(0)) u0 (
        .clk(clk), .rst(rst), .data_in(din0), .data_valid(dv0), .data_ready(rdy0),
        .sout(so0), .sout_valid(sv0), .word_start(ws0), .word_done(wd0), .busy(bz0)
    );

    always @(negedge clk) begin
        cyc++;
        if (sv2) begin
            acc2 = ws2 ? {7'b0, so2} : {acc2[6:0], so2};
            nb2 = ws2 ? 1 : nb2 + 1;
            if (ws2) st2.push_back(cyc);
            if (wd2) begin
                rx2.push_back(acc2);
                rxn2.push_back(nb2);
            end
        end
        if (sv0) begin
            acc0 = ws0 ? {7'b0, so0} : {acc0[6:0], so0};
            nb0 = ws0 ? 1 : nb0 + 1;
            nvalid0++;
            if (ws0 && first0 < 0) first0 = cyc;
            if (wd0) begin
                rx0.push_back(acc0);
                last0 = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic offer(input int sel, input int k, input logic [2:0] w [4]);
        int i = 0, n = 0;
        logic r;
        while (i < k && n < 200) begin
            @(negedge clk);
            if (sel == 0) begin
                r = rdy0;
                dv0 = 1'b1;
                din0 = r ? w[i] : ~w[i];
            end else begin
                r = rdy2;
                dv2 = 1'b1;
                din2 = r ? w[i] : ~w[i];
            end
            @(posedge clk);
            if (r) i++;
            n++;
        end
        @(negedge clk);
        dv0 = 1'b0;
        dv2 = 1'b0;
        chk("offer_accepted", i, k);
        n = 0;
        while ((sel == 0 ? bz0 : bz2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("offer_idle", sel == 0 ? bz0 : bz2, 0);
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [2:0] d;
        logic [5:0] e;
    } vec_t;

    initial begin
        logic [2:0] w [4];
`ifdef SERIAL_WORD_TX_PARITY_EN
        rst = 1'b1;
        dv2 = 1'b1;
        din2 = 3'b101;
        repeat (2) @(posedge clk);
        #1;
        chk("par_reset_ready", rdy2, 1);
        chk("par_reset_busy", bz2, 0);
        chk("par_reset_sv", sv2, 0);
        @(negedge clk);
        rst = 1'b0;
        dv2 = 1'b0;
        rx2.delete(); rxn2.delete(); st2.delete();
        w = '{3'b110, 3'b111, 3'b000, 3'b000};
        offer(2, 2, w);
        chk("par_count", rx2.size(), 2);
        chk("par_word0", rx2[0], 8'b1100);
        chk("par_word1", rx2[1], 8'b1111);
        chk("par_bits0", rxn2[0], 4);
        chk("par_bits1", rxn2[1], 4);
        chk("par_spacing", st2[1] - st2[0], 6);
`else
        vec_t tbl [21];
        tbl = '{
            '{1'b1, 1'b1, 3'b101, 6'b000010},
            '{1'b1, 1'b1, 3'b101, 6'b000010},
            '{1'b0, 1'b1, 3'b101, 6'b000001},
            '{1'b0, 1'b0, 3'b000, 6'b111011},
            '{1'b0, 1'b0, 3'b000, 6'b010011},
            '{1'b0, 1'b0, 3'b000, 6'b110111},
            '{1'b0, 1'b0, 3'b000, 6'b000011},
            '{1'b0, 1'b0, 3'b000, 6'b000011},
            '{1'b0, 1'b0, 3'b000, 6'b000010},
            '{1'b0, 1'b1, 3'b110, 6'b000001},
            '{1'b0, 1'b1, 3'b000, 6'b111011},
            '{1'b0, 1'b1, 3'b011, 6'b110001},
            '{1'b0, 1'b0, 3'b000, 6'b010101},
            '{1'b0, 1'b0, 3'b000, 6'b000001},
            '{1'b0, 1'b0, 3'b000, 6'b000001},
            '{1'b0, 1'b0, 3'b000, 6'b011011},
            '{1'b0, 1'b0, 3'b000, 6'b110011},
            '{1'b0, 1'b0, 3'b000, 6'b110111},
            '{1'b0, 1'b0, 3'b000, 6'b000011},
            '{1'b0, 1'b0, 3'b000, 6'b000011},
            '{1'b0, 1'b0, 3'b000, 6'b000010}
        };
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            rst = tbl[i].r;
            dv2 = tbl[i].v;
            din2 = tbl[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d", i), {so2, sv2, ws2, wd2, rdy2, bz2}, tbl[i].e);
        end
        chk("tbl_count", rx2.size(), 3);
        chk("tbl_word0", rx2[0], 8'b101);
        chk("tbl_word1", rx2[1], 8'b110);
        chk("tbl_word2", rx2[2], 8'b011);
        chk("tbl_spacing", st2[2] - st2[1], 5);

        rx2.delete(); rxn2.delete();
        w = '{3'b101, 3'b010, 3'b111, 3'b001};
        offer(2, 4, w);
        chk("bp2_count", rx2.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp2_word%0d", i), rx2[i], {5'b0, w[i]});

        offer(0, 4, w);
        chk("bp0_count", rx0.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp0_word%0d", i), rx0[i], {5'b0, w[i]});
        chk("bp0_gapless", last0 - first0 + 1, 12);
        chk("bp0_valid_bits", nvalid0, 12);

        rx2.delete(); rxn2.delete();
        @(negedge clk);
        dv2 = 1'b1;
        din2 = 3'b100;
        @(posedge clk);
        @(negedge clk);
        dv2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_second_bit", {so2, sv2}, 2'b01);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_sv", sv2, 0);
        chk("mid_rst_sout", so2, 0);
        chk("mid_rst_ready", rdy2, 1);
        chk("mid_rst_busy", bz2, 0);
        @(negedge clk);
        rst = 1'b0;
        w = '{3'b111, 3'b000, 3'b000, 3'b000};
        offer(2, 1, w);
        chk("mid_count", rx2.size(), 1);
        chk("mid_word", rx2[0], 8'b111);
        chk("mid_bits", rxn2[0], 3);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
